core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 The module SHALL have parameter TIMEOUT, default 8'd255, the maximum memory wait cycles before error.
REQ-003 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port imem_req  output  1  instruction fetch request.
REQ-006 Port imem_addr  output  32  fetch address; equals pc.
REQ-007 Port imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-008 Port imem_rdata  input  32  fetched instruction word.
REQ-009 Port instr  output  32  latched instruction register, driven to the decoder.
REQ-010 Port is_load, is_store, is_branch, is_jump, is_ecall  input  1 each  decoder class flags derived from instr.
REQ-011 Port branch_taken  input  1  branch comparison result.
REQ-012 Port alu_result  input  32  branch/jump target address.
REQ-013 Port dmem_req  output  1  data memory request.
REQ-014 Port dmem_we  output  1  data write qualifier, valid with dmem_req.
REQ-015 Port dmem_ack  input  1  data access complete.
REQ-016 Port rf_read_en, rf_write_en  output  1 each  register file port enables.
REQ-017 Port pc  output  32  current program counter.
REQ-018 Port retire  output  1  one-cycle pulse per completed instruction.
REQ-019 Port halted, error  output  1 each  sticky status flags.

Function
REQ-020 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT, ERR, registered and binary encoded.
REQ-021 FETCH: imem_req=1 and imem_addr=pc every cycle; on imem_ack, instr<=imem_rdata and next state DECODE.
REQ-022 DECODE: rf_read_en=1 for exactly this one cycle; next state EXEC.
REQ-023 EXEC: sample decoder flags; is_ecall -> HALT; is_load or is_store -> MEM; else -> WB.
REQ-024 MEM: dmem_req=1 and dmem_we=is_store held until dmem_ack; on ack, store -> FETCH with PC update and retire, load -> WB.
REQ-025 WB: rf_write_en=1 unless is_branch or is_store; PC update and retire=1; next state FETCH.
REQ-026 PC update: pc <= (is_jump or (is_branch and branch_taken)) ? alu_result : pc+32'd4, modulo 2^32 (0xFFFF_FFFC+4 -> 0).
REQ-027 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without ack.
REQ-028 If the wait counter equals TIMEOUT and ack is low, next state SHALL be ERR; ack in the same cycle wins.
REQ-029 HALT: halted=1, all requests and enables 0, pc frozen; leaves only on reset.
REQ-030 ERR: error=1, all requests and enables 0, pc frozen at faulting instruction; leaves only on reset.
REQ-031 Minimum latency: ALU op 4 cycles FETCH->next FETCH with single-cycle ack; load 5; store 4.
REQ-032 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.

Reset
REQ-033 While rst=0: state=FETCH, pc=RESET_PC, instr=0, wait counter=0, all other outputs 0, asynchronously.
REQ-034 imem_req SHALL assert in the first cycle after rst deasserts.
REQ-035 Reset during any state, including mid-MEM, SHALL abort the access with no rf_write_en or retire.

Verification
REQ-036 Reset release, RESET_PC=0 -> imem_req=1, imem_addr=0, halted=0, error=0 next cycle.
REQ-037 ADD with immediate acks -> rf_read_en at cycle 2, rf_write_en and retire at cycle 4, pc=4 after.
REQ-038 Load, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_write_en one cycle later.
REQ-039 Taken branch, alu_result=0x40 -> rf_write_en=0, retire=1, pc=0x40.
REQ-040 ECALL -> HALT after EXEC, halted=1, no further imem_req for 20 cycles.
REQ-041 No imem_ack, TIMEOUT=255 -> error=1 after 256 FETCH cycles; ack on cycle 256 -> DECODE, no error.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Owns the PC and instruction register and drives memory requests and register-file enables.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        is_ecall,
  input  logic        branch_taken,
  input  logic [31:0] alu_result,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_read_en,
  output logic        rf_write_en,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  output logic        error,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [7:0]  wait_cnt_q;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] instr_q;
  logic        store_q;
  logic        branch_q;
  logic        jump_q;
  logic        retire_c;
  logic        timed_out;

  // Handshake: a request (imem_req in FETCH, dmem_req in MEM) is held every
  // cycle until the matching ack is seen; an ack in any other state is ignored.
  assign timed_out = (wait_cnt_q == TIMEOUT);
  assign pc_next   = (jump_q || (branch_q && branch_taken)) ? alu_result : pc_q + 32'd4;
  assign retire_c  = (state_q == WB) || ((state_q == MEM) && dmem_ack && store_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (imem_ack)       state_d = DECODE;
        else if (timed_out) state_d = ERR;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_ecall)                 state_d = HALT;
        else if (is_load || is_store) state_d = MEM;
        else                          state_d = WB;
      end
      MEM: begin
        if (dmem_ack)       state_d = store_q ? FETCH : WB;
        else if (timed_out) state_d = ERR;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      wait_cnt_q <= 8'd0;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      store_q    <= 1'b0;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEM)))
        wait_cnt_q <= 8'd0;
      else if (((state_q == FETCH) && !imem_ack) || ((state_q == MEM) && !dmem_ack))
        wait_cnt_q <= wait_cnt_q + 8'd1;
      if ((state_q == FETCH) && imem_ack)
        instr_q <= imem_rdata;
      // Class flags are captured once so MEM/WB see a stable view of the instruction.
      if (state_q == EXEC) begin
        store_q  <= is_store;
        branch_q <= is_branch;
        jump_q   <= is_jump;
      end
      if (retire_c)
        pc_q <= pc_next;
    end
  end

  // imem_req is gated by reset so every output except pc reads zero while held in reset.
  assign imem_req    = rst && (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign dmem_req    = (state_q == MEM);
  assign dmem_we     = (state_q == MEM) && store_q;
  assign rf_read_en  = (state_q == DECODE);
  assign rf_write_en = (state_q == WB) && !branch_q && !store_q;
  assign pc          = pc_q;
  assign retire      = retire_c;
  assign halted      = (state_q == HALT);
  assign error       = (state_q == ERR);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: acts as instruction/data memory and decoder, and
// scoreboards every retirement against a small PC/write-enable model.
module tb_core_sequencer;

  localparam int W = 33;
  localparam logic [2:0] C_ALU = 3'd0, C_LD = 3'd1, C_ST = 3'd2, C_BR = 3'd3, C_JMP = 3'd4, C_ECALL = 3'd5;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0, instr;
  logic        is_load, is_store, is_branch, is_jump, is_ecall, branch_taken;
  logic [31:0] alu_result;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        rf_read_en, rf_write_en, retire, halted, error;
  logic [31:0] pc;
  logic [2:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [31:0]  model_pc = RESET_PC;
  int           n_checks = 0;
  int           n_pass = 0;
  bit           pend = 0;
  logic [31:0]  pend_pc;

  core_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(8'd255)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump), .is_ecall(is_ecall),
    .branch_taken(branch_taken), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
    .pc(pc), .retire(retire), .halted(halted), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // toy decoder: instr[2:0] = class, instr[3] = taken, target = instr with low nibble cleared
  always_comb begin
    is_load      = (instr[2:0] == C_LD);
    is_store     = (instr[2:0] == C_ST);
    is_branch    = (instr[2:0] == C_BR);
    is_jump      = (instr[2:0] == C_JMP);
    is_ecall     = (instr[2:0] == C_ECALL);
    branch_taken = instr[3];
    alu_result   = {instr[31:4], 4'b0000};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  // scoreboard: pop on every retire, then check the PC that follows it
  always @(negedge clk) begin
    logic [W-1:0] e;
    #2;
    if (!rst) pend = 0;
    else if (pend) begin
      check_eq("retire_pulse", 64'(retire), 64'd0);
      check_eq("pc_after_retire", 64'(pc), 64'(pend_pc));
      pend = 0;
    end else if (retire) begin
      if (exp_q.size() == 0) check_eq("retire_unexpected", 64'(retire), 64'd0);
      else begin
        e = exp_q.pop_front();
        check_eq("wb_enable", 64'(rf_write_en), 64'(e[32]));
        pend    = 1;
        pend_pc = e[31:0];
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_outputs", 64'({imem_req, dmem_req, dmem_we, rf_read_en, rf_write_en, retire, halted, error}), 64'd0);
    check_eq("rst_pc_instr", {pc, instr}, {RESET_PC, 32'd0});
    check_eq("rst_state", 64'(dbg_state), 64'(C_ALU));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_pc = RESET_PC;
    #1;
    check_eq("release_fetch", 64'({imem_req, halted, error}), 64'b100);
    check_eq("release_addr", 64'(imem_addr), 64'(RESET_PC));
  endtask

  task automatic run_instr(input logic [31:0] word, input int ilat, input int dlat, input bit abort, input bit spur);
    logic [2:0]  cls;
    logic [31:0] npc;
    bit          wen;
    int          n;
    cls = word[2:0];
    npc = ((cls == C_JMP) || ((cls == C_BR) && word[3])) ? {word[31:4], 4'b0000} : model_pc + 32'd4;
    wen = (cls == C_ALU) || (cls == C_LD) || (cls == C_JMP);
    @(negedge clk);
    n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    check_eq("fetch_req", 64'(imem_req), 64'd1);
    check_eq("fetch_addr", 64'(imem_addr), 64'(model_pc));
    repeat (ilat) @(negedge clk);
    if ((cls != C_ECALL) && !(abort && (cls == C_LD || cls == C_ST))) exp_q.push_back({wen, npc});
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
    check_eq("decode_rd_en", 64'(rf_read_en), 64'd1);
    check_eq("instr_latched", 64'(instr), 64'(word));
    if (spur) begin imem_ack = 1'b1; dmem_ack = 1'b1; end
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    check_eq("exec_rd_en_low", 64'(rf_read_en), 64'd0);
    if (spur) check_eq("spurious_ack_ignored", 64'({instr, dbg_state}), 64'({word, 3'd2}));
    @(negedge clk);
    if (cls == C_ECALL) begin
      check_eq("ecall_halted", 64'({halted, error}), 64'b10);
      n = 0;
      repeat (20) begin @(negedge clk); if (imem_req || retire || rf_write_en) n++; end
      check_eq("halt_quiet", 64'(n), 64'd0);
      check_eq("halt_pc_frozen", 64'(pc), 64'(model_pc));
    end else if (cls == C_LD || cls == C_ST) begin
      check_eq("dmem_we", 64'(dmem_we), 64'(cls == C_ST));
      n = 0;
      for (int i = 0; i < dlat; i++) begin if (dmem_req) n++; @(negedge clk); end
      if (dmem_req) n++;
      if (abort) begin
        rst = 1'b0;
        #1;
        check_eq("abort_outputs", 64'({dmem_req, retire, rf_write_en}), 64'd0);
        check_eq("abort_pc", 64'(pc), 64'(RESET_PC));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_pc = RESET_PC;
      end else begin
        dmem_ack = 1'b1;
        #1;
        if (cls == C_ST) check_eq("store_retire", 64'(retire), 64'd1);
        @(negedge clk);
        dmem_ack = 1'b0;
        check_eq("dmem_req_cycles", 64'(n), 64'(dlat + 1));
        if (cls == C_LD) check_eq("load_wb", 64'({retire, rf_write_en}), 64'b11);
        model_pc = npc;
      end
    end else begin
      #1;
      check_eq("wb_retire", 64'(retire), 64'd1);
      model_pc = npc;
    end
  endtask

  initial begin
    int n;
    logic [31:0] w;
    reset_dut();
    run_instr(32'h0000_0010, 0, 0, 0, 0);   // ADD, single-cycle acks
    run_instr(32'h0000_0021, 0, 3, 0, 0);   // load, dmem ack after 3 waits
    run_instr(32'h0000_0032, 0, 0, 0, 0);   // store
    run_instr(32'h0000_0042, 1, 2, 0, 0);   // store with waits
    run_instr(32'h0000_004B, 0, 0, 0, 0);   // taken branch to 0x40
    run_instr(32'h0000_0053, 0, 0, 0, 0);   // not-taken branch
    run_instr(32'hFFFF_FFF4, 0, 0, 0, 0);   // jump to 0xFFFF_FFF0
    for (int i = 0; i < 4; i++) run_instr(32'h0000_0100, $urandom_range(0, 3), 0, 0, (i == 1));
    check_eq("pc_wrap", 64'(model_pc), 64'd0);
    for (int i = 0; i < 10; i++) begin
      w = ($urandom & 32'hFFFF_FFF0) | {28'd0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4))};
      run_instr(w, $urandom_range(0, 4), $urandom_range(0, 4), 0, 1'($urandom_range(0, 1)));
    end
    run_instr(32'h0000_0071, 0, 2, 1, 0);   // load aborted by reset in MEM
    run_instr(32'h0000_0010, 0, 0, 0, 0);
    run_instr(32'h0000_0005, 0, 0, 0, 0);   // ECALL

    // fetch timeout: no ack at all
    reset_dut();
    n = 0;
    while (!error && n < 400) begin if (imem_req) n++; @(negedge clk); end
    check_eq("timeout_cycles", 64'(n), 64'd256);
    check_eq("timeout_err", 64'({error, halted, imem_req, retire}), 64'b1000);
    check_eq("timeout_pc", 64'(pc), 64'(RESET_PC));

    // ack on the last allowed cycle still wins
    reset_dut();
    repeat (255) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0005;
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("late_ack_decode", 64'({rf_read_en, error}), 64'b10);
    repeat (2) @(negedge clk);
    check_eq("late_ack_halt", 64'({halted, error}), 64'b10);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
